// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, selects, ALU ops, decode classes.
package multi_cycle_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] F_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] F_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'h2A;

  // Code 11 is reserved on reg_dst_sel and wb_sel.
  typedef enum logic [SEL_W-1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10} reg_dst_t;
  typedef enum logic [SEL_W-1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10} wb_sel_t;
  typedef enum logic [SEL_W-1:0] {
    PC_PLUS4 = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11
  } pc_sel_t;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4
  } alu_op_t;

  typedef enum logic [3:0] {
    CL_RTYPE, CL_JR, CL_ADDI, CL_ORI, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_ILLEGAL
  } iclass_t;

  // Classifier result: instruction class plus the ALU op an R-type funct asks for.
  typedef struct packed {
    iclass_t iclass;
    alu_op_t rtype_op;
  } decode_t;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and flags in, strobes and selects out.
interface multi_cycle_ctrl_if;
  import multi_cycle_ctrl_pkg::*;

  logic [OP_W-1:0]     op;
  logic [FUNCT_W-1:0]  funct;
  logic                zero;
  logic                mem_ready;
  logic                pc_we;
  logic                ir_we;
  logic                reg_we;
  logic                mem_re;
  logic                mem_we;
  logic                illegal;
  logic                alu_src_sel;
  logic [SEL_W-1:0]    reg_dst_sel;
  logic [SEL_W-1:0]    wb_sel;
  logic [SEL_W-1:0]    pc_sel;
  logic [ALU_OP_W-1:0] alu_op;
  logic [STATE_W-1:0]  state;

  // Datapath side.
  modport master (
    output op, funct, zero, mem_ready,
    input  pc_we, ir_we, reg_we, mem_re, mem_we, illegal,
    input  alu_src_sel, reg_dst_sel, wb_sel, pc_sel, alu_op, state
  );

  // Controller side.
  modport slave (
    input  op, funct, zero, mem_ready,
    output pc_we, ir_we, reg_we, mem_re, mem_we, illegal,
    output alu_src_sel, reg_dst_sel, wb_sel, pc_sel, alu_op, state
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: op/funct -> instruction class and R-type ALU op.
module ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  output decode_t            dec
);

  // Anything not matched falls through to ILLEGAL.
  always_comb begin
    dec.iclass   = CL_ILLEGAL;
    dec.rtype_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD: begin dec.iclass = CL_RTYPE; dec.rtype_op = ALU_ADD; end
          F_SUB: begin dec.iclass = CL_RTYPE; dec.rtype_op = ALU_SUB; end
          F_AND: begin dec.iclass = CL_RTYPE; dec.rtype_op = ALU_AND; end
          F_OR:  begin dec.iclass = CL_RTYPE; dec.rtype_op = ALU_OR;  end
          F_SLT: begin dec.iclass = CL_RTYPE; dec.rtype_op = ALU_SLT; end
          F_JR:  dec.iclass = CL_JR;
          default: ;
        endcase
      end
      OP_J:    dec.iclass = CL_J;
      OP_JAL:  dec.iclass = CL_JAL;
      OP_BEQ:  dec.iclass = CL_BEQ;
      OP_ADDI: dec.iclass = CL_ADDI;
      OP_ORI:  dec.iclass = CL_ORI;
      OP_LW:   dec.iclass = CL_LW;
      OP_SW:   dec.iclass = CL_SW;
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: IF/ID/EX/MEM/WB with memory handshake waits.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  multi_cycle_ctrl_if.slave bus
);

  state_t   state_q;
  state_t   state_n;
  decode_t  dec;

  logic     pc_we, ir_we, reg_we, mem_re, mem_we, illegal, alu_src_sel;
  reg_dst_t reg_dst_sel;
  wb_sel_t  wb_sel;
  pc_sel_t  pc_sel;
  alu_op_t  alu_op;

  ctrl_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .dec   (dec)
  );

  // State register; reset overrides any pending memory wait.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IF;
    else       state_q <= state_n;
  end

  // Next state and outputs; outputs are combinational by design (pure function of state and inputs).
  always_comb begin
    state_n     = state_q;
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    illegal     = 1'b0;
    alu_src_sel = 1'b0;
    reg_dst_sel = DST_RT;
    wb_sel      = WB_ALU;
    pc_sel      = PC_PLUS4;
    alu_op      = ALU_ADD;
    case (state_q)
      ST_IF: begin
        mem_re = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_n = ST_ID;
        end
      end
      ST_ID: begin
        case (dec.iclass)
          CL_J:       begin pc_we = 1'b1; pc_sel = PC_JUMP; state_n = ST_IF; end
          CL_JAL:     state_n = ST_WB;
          CL_ILLEGAL: begin illegal = 1'b1; state_n = ST_IF; end
          default:    state_n = ST_EX;
        endcase
      end
      ST_EX: begin
        state_n = ST_IF;
        case (dec.iclass)
          CL_RTYPE: begin alu_op = dec.rtype_op; state_n = ST_WB; end
          CL_JR:    begin pc_we = 1'b1; pc_sel = PC_RS; end
          CL_ADDI:  begin alu_src_sel = 1'b1; alu_op = ALU_ADD; state_n = ST_WB; end
          CL_ORI:   begin alu_src_sel = 1'b1; alu_op = ALU_OR;  state_n = ST_WB; end
          CL_LW,
          CL_SW:    begin alu_src_sel = 1'b1; alu_op = ALU_ADD; state_n = ST_MEM; end
          CL_BEQ:   begin alu_op = ALU_SUB; pc_sel = PC_BRANCH; pc_we = bus.zero; end
          default: ;
        endcase
      end
      ST_MEM: begin
        state_n = ST_IF;
        if (dec.iclass == CL_LW) begin
          mem_re  = 1'b1;
          state_n = bus.mem_ready ? ST_WB : ST_MEM;
        end else if (dec.iclass == CL_SW) begin
          mem_we  = 1'b1;
          state_n = bus.mem_ready ? ST_IF : ST_MEM;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        state_n = ST_IF;
        case (dec.iclass)
          CL_RTYPE: reg_dst_sel = DST_RD;
          CL_LW:    wb_sel = WB_MEM;
          CL_JAL:   begin
            reg_dst_sel = DST_RA;
            wb_sel      = WB_PC;
            pc_we       = 1'b1;
            pc_sel      = PC_JUMP;
          end
          default: ;
        endcase
      end
      default: state_n = ST_IF;
    endcase
    // Reset quiets every control output in the same cycle.
    if (reset) begin
      state_n     = ST_IF;
      pc_we       = 1'b0;
      ir_we       = 1'b0;
      reg_we      = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      illegal     = 1'b0;
      alu_src_sel = 1'b0;
      reg_dst_sel = DST_RT;
      wb_sel      = WB_ALU;
      pc_sel      = PC_PLUS4;
      alu_op      = ALU_ADD;
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.ir_we       = ir_we;
  assign bus.reg_we      = reg_we;
  assign bus.mem_re      = mem_re;
  assign bus.mem_we      = mem_we;
  assign bus.illegal     = illegal;
  assign bus.alu_src_sel = alu_src_sel;
  assign bus.reg_dst_sel = reg_dst_sel;
  assign bus.wb_sel      = wb_sel;
  assign bus.pc_sel      = pc_sel;
  assign bus.alu_op      = alu_op;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed, table-driven bench for multi_cycle_ctrl: one record per clock cycle.
module tb_multi_cycle_ctrl;

  // Expected encodings, written out independently of the design package.
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;
  localparam logic [5:0] P = 6'b100000;  // pc_we
  localparam logic [5:0] I = 6'b010000;  // ir_we
  localparam logic [5:0] R = 6'b001000;  // reg_we
  localparam logic [5:0] M = 6'b000100;  // mem_re
  localparam logic [5:0] W = 6'b000010;  // mem_we
  localparam logic [5:0] L = 6'b000001;  // illegal

  typedef struct {
    string      nm;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    logic [18:0] exp;
  } vec_t;

  vec_t vq[$];

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] actual();
    return {bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_re, bus.mem_we, bus.illegal,
            bus.alu_src_sel, bus.reg_dst_sel, bus.wb_sel, bus.pc_sel, bus.alu_op, bus.state};
  endfunction

  task automatic add(input string nm, input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic rdy, input logic [2:0] st, input logic [5:0] stb,
                     input logic src, input logic [1:0] dst, input logic [1:0] wb,
                     input logic [1:0] pcs, input logic [2:0] aop);
    vec_t v;
    v.nm = nm; v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rdy;
    v.exp = {stb, src, dst, wb, pcs, aop, st};
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, req);
  endtask

  initial begin
    int cyc, mre, waits;
    bit done;
    logic [2:0] st;

    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    //  name          rst op     funct  z  rdy st     strobes  src dst    wb     pcs    aop
    add("rst_hold",   1, 6'h00, 6'h00, 0, 1, S_IF,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("rst_rel_if", 0, 6'h00, 6'h20, 0, 0, S_IF,  M,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("add_if",     0, 6'h00, 6'h20, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("add_id",     0, 6'h00, 6'h20, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("add_ex",     0, 6'h00, 6'h20, 0, 1, S_EX,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("add_wb",     0, 6'h00, 6'h20, 0, 1, S_WB,  R,       0, 2'b01, 2'b00, 2'b00, 3'd0);
    add("sub_if",     0, 6'h00, 6'h22, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("sub_id",     0, 6'h00, 6'h22, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("sub_ex",     0, 6'h00, 6'h22, 0, 1, S_EX,  0,       0, 2'b00, 2'b00, 2'b00, 3'd1);
    add("sub_wb",     0, 6'h00, 6'h22, 0, 1, S_WB,  R,       0, 2'b01, 2'b00, 2'b00, 3'd0);
    add("slt_if",     0, 6'h00, 6'h2A, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("slt_id",     0, 6'h00, 6'h2A, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("slt_ex",     0, 6'h00, 6'h2A, 0, 1, S_EX,  0,       0, 2'b00, 2'b00, 2'b00, 3'd4);
    add("slt_wb",     0, 6'h00, 6'h2A, 0, 1, S_WB,  R,       0, 2'b01, 2'b00, 2'b00, 3'd0);
    add("or_if",      0, 6'h00, 6'h25, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("or_id",      0, 6'h00, 6'h25, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("or_ex",      0, 6'h00, 6'h25, 0, 1, S_EX,  0,       0, 2'b00, 2'b00, 2'b00, 3'd3);
    add("or_wb",      0, 6'h00, 6'h25, 0, 1, S_WB,  R,       0, 2'b01, 2'b00, 2'b00, 3'd0);
    add("addi_if",    0, 6'h08, 6'h00, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("addi_id",    0, 6'h08, 6'h00, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("addi_ex",    0, 6'h08, 6'h00, 0, 1, S_EX,  0,       1, 2'b00, 2'b00, 2'b00, 3'd0);
    add("addi_wb",    0, 6'h08, 6'h00, 0, 1, S_WB,  R,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("ori_if",     0, 6'h0D, 6'h00, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("ori_id",     0, 6'h0D, 6'h00, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("ori_ex",     0, 6'h0D, 6'h00, 0, 1, S_EX,  0,       1, 2'b00, 2'b00, 2'b00, 3'd3);
    add("ori_wb",     0, 6'h0D, 6'h00, 0, 1, S_WB,  R,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("lw_if",      0, 6'h23, 6'h15, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("lw_id",      0, 6'h23, 6'h15, 0, 0, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("lw_ex",      0, 6'h23, 6'h15, 0, 0, S_EX,  0,       1, 2'b00, 2'b00, 2'b00, 3'd0);
    add("lw_mem_w1",  0, 6'h23, 6'h15, 0, 0, S_MEM, M,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("lw_mem_w2",  0, 6'h23, 6'h15, 0, 0, S_MEM, M,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("lw_mem_w3",  0, 6'h23, 6'h15, 0, 0, S_MEM, M,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("lw_mem_ok",  0, 6'h23, 6'h15, 0, 1, S_MEM, M,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("lw_wb",      0, 6'h23, 6'h15, 0, 1, S_WB,  R,       0, 2'b00, 2'b01, 2'b00, 3'd0);
    add("sw_if",      0, 6'h2B, 6'h00, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("sw_id",      0, 6'h2B, 6'h00, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("sw_ex",      0, 6'h2B, 6'h00, 0, 0, S_EX,  0,       1, 2'b00, 2'b00, 2'b00, 3'd0);
    add("sw_mem_w1",  0, 6'h2B, 6'h00, 0, 0, S_MEM, W,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("sw_mem_ok",  0, 6'h2B, 6'h00, 0, 1, S_MEM, W,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("beq1_if",    0, 6'h04, 6'h00, 1, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("beq1_id",    0, 6'h04, 6'h00, 1, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("beq1_ex",    0, 6'h04, 6'h00, 1, 1, S_EX,  P,       0, 2'b00, 2'b00, 2'b01, 3'd1);
    add("beq0_if",    0, 6'h04, 6'h00, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("beq0_id",    0, 6'h04, 6'h00, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("beq0_ex",    0, 6'h04, 6'h00, 0, 1, S_EX,  0,       0, 2'b00, 2'b00, 2'b01, 3'd1);
    add("j_if",       0, 6'h02, 6'h00, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("j_id",       0, 6'h02, 6'h00, 0, 1, S_ID,  P,       0, 2'b00, 2'b00, 2'b10, 3'd0);
    add("jal_if",     0, 6'h03, 6'h00, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("jal_id",     0, 6'h03, 6'h00, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("jal_wb",     0, 6'h03, 6'h00, 0, 1, S_WB,  R|P,     0, 2'b10, 2'b10, 2'b10, 3'd0);
    add("jr_if",      0, 6'h00, 6'h08, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("jr_id",      0, 6'h00, 6'h08, 0, 1, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("jr_ex",      0, 6'h00, 6'h08, 0, 1, S_EX,  P,       0, 2'b00, 2'b00, 2'b11, 3'd0);
    add("ill_if",     0, 6'h3F, 6'h00, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("ill_id",     0, 6'h3F, 6'h00, 0, 1, S_ID,  L,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("ill_back",   0, 6'h3F, 6'h00, 0, 0, S_IF,  M,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("illf_if",    0, 6'h00, 6'h3F, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("illf_id",    0, 6'h00, 6'h3F, 0, 1, S_ID,  L,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("swr_if",     0, 6'h2B, 6'h00, 0, 1, S_IF,  P|I|M,   0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("swr_id",     0, 6'h2B, 6'h00, 0, 0, S_ID,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("swr_ex",     0, 6'h2B, 6'h00, 0, 0, S_EX,  0,       1, 2'b00, 2'b00, 2'b00, 3'd0);
    add("swr_mem_w1", 0, 6'h2B, 6'h00, 0, 0, S_MEM, W,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("swr_mem_w2", 0, 6'h2B, 6'h00, 0, 0, S_MEM, W,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("swr_rst_in", 1, 6'h2B, 6'h00, 0, 0, S_MEM, 0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("swr_rst_if", 1, 6'h2B, 6'h00, 0, 0, S_IF,  0,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("swr_rel_1",  0, 6'h2B, 6'h00, 0, 0, S_IF,  M,       0, 2'b00, 2'b00, 2'b00, 3'd0);
    add("swr_rel_2",  0, 6'h2B, 6'h00, 0, 0, S_IF,  M,       0, 2'b00, 2'b00, 2'b00, 3'd0);

    repeat (2) @(posedge clk);

    // Table pass: drive at the falling edge, compare shortly after.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset         = vq[i].rst;
      bus.op        = vq[i].op;
      bus.funct     = vq[i].funct;
      bus.zero      = vq[i].zero;
      bus.mem_ready = vq[i].rdy;
      #1;
      check(vq[i].nm, 32'(actual()), 32'(vq[i].exp));
    end

    // lw with three MEM wait cycles: total cycle count and mem_re cycles in MEM.
    cyc = 0; mre = 0; waits = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      st = bus.state;
      bus.op    = 6'h23;
      bus.funct = 6'h00;
      if (st == S_MEM) begin
        bus.mem_ready = (waits == 3);
        if (waits < 3) waits++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      #1;
      cyc++;
      if (st == S_MEM && bus.mem_re) mre++;
      @(posedge clk);
      #1;
      if (bus.state == S_IF) done = 1'b1;
    end
    check("lw_seq_done", 32'(done), 32'd1);
    check("lw_seq_cycles", 32'(cyc), 32'd8);
    check("lw_seq_mem_re", 32'(mre), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have ports clk, input, 1, the single clock, with all state changing on its rising edge.
REQ-002 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have ports op and funct, input, 6 each, carrying the IR opcode and function fields.
REQ-004 The block SHALL have port zero, input, 1, the ALU zero flag.
REQ-005 The block SHALL have port mem_ready, input, 1, a memory completion handshake.
REQ-006 The block SHALL have outputs pc_we, ir_we, reg_we, mem_re, mem_we and illegal, 1 bit each, all strobes.
REQ-007 The block SHALL have output alu_src_sel, 1 bit: 0 selects register B, 1 selects the sign/zero-extended immediate.
REQ-008 The block SHALL have output reg_dst_sel, 2 bits: 00 rt, 01 rd, 10 $31.
REQ-009 The block SHALL have output wb_sel, 2 bits: 00 ALU result, 01 memory data, 10 PC.
REQ-010 The block SHALL have output pc_sel, 2 bits: 00 PC+4, 01 branch target, 10 jump target, 11 rs.
REQ-011 The block SHALL have output alu_op, 3 bits: add, sub, and, or, slt.
REQ-012 The block SHALL have output state, 3 bits, exposing the current FSM state for debug.
REQ-013 Select code 11 on reg_dst_sel and wb_sel SHALL be reserved and never driven.

Function
REQ-014 The FSM SHALL have states IF, ID, EX, MEM and WB, each encoded as a package constant.
- Decisions SHALL use op and funct sampled combinationally; the IR is held stable from ID onward.
REQ-015 In IF the block SHALL hold mem_re=1 and wait while mem_ready=0.
- When mem_ready=1: ir_we=1, pc_we=1, pc_sel=00 for exactly that cycle, then go to ID.
REQ-016 In ID, for j: pc_we=1 and pc_sel=10, then go to IF.
- jal: go to WB.
- Illegal op or funct: illegal=1 for one cycle, then go to IF.
- All other instructions: go to EX.
REQ-017 In EX, for R-type (op 0x00) add/sub/and/or/slt: alu_src_sel=0 and the matching alu_op, then go to WB.
- jr (funct 0x08): pc_we=1, pc_sel=11, then go to IF.
REQ-018 In EX, for addi (0x08): alu_src_sel=1, alu_op add, then go to WB.
- ori (0x0D): alu_src_sel=1, alu_op or, then go to WB.
- lw (0x23) and sw (0x2B): alu_src_sel=1, alu_op add, then go to MEM.
REQ-019 In EX, for beq (0x04): alu_op sub, pc_sel=01, pc_we=zero, then go to IF.
REQ-020 In MEM, lw SHALL assert mem_re and sw SHALL assert mem_we until mem_ready=1.
- On mem_ready=1, lw goes to WB and sw goes to IF.
- mem_we SHALL be high for no more than the wait cycles plus the completion cycle.
REQ-021 In WB the block SHALL assert reg_we=1 for one cycle, then go to IF, with selects as follows:
- R-type: reg_dst_sel=01, wb_sel=00.
- addi/ori: reg_dst_sel=00, wb_sel=00.
- lw: reg_dst_sel=00, wb_sel=01.
- jal: reg_dst_sel=10, wb_sel=10, plus pc_we=1 and pc_sel=10 in the same cycle, so the PC+4 written is the pre-jump value.
REQ-022 Every output not named for the current state and instruction SHALL be 0, and outputs SHALL be a pure function of state, op, funct, zero and mem_ready.
REQ-023 Every instruction SHALL cost exactly its state count, with no extra cycles apart from mem_ready wait cycles:
- j: 2 cycles. beq and jr: 3. R-type, addi and ori: 4. sw: 4. lw: 5.

Reset
REQ-024 reset=1 at a clock edge SHALL force state to IF, regardless of the current state or any pending mem_ready wait.
REQ-025 While reset=1, every strobe output SHALL be 0, and all select, alu_op and illegal outputs SHALL be 0.
REQ-026 In the first cycle after reset deasserts, state SHALL be IF and mem_re SHALL be 1.

Structure
REQ-027 A shared package SHALL hold:
- the state codes;
- the opcode and funct constants;
- the reg_dst_sel, wb_sel and pc_sel codes;
- the alu_op codes.
REQ-028 The combinational instruction classifier SHALL be one sub-module, ctrl_decode.
- It maps op/funct to a class: RTYPE, JR, ADDI, ORI, LW, SW, BEQ, J, JAL or ILLEGAL.
- The FSM in multi_cycle_ctrl consumes only that class, plus zero and mem_ready.

Verification
REQ-029 The bench SHALL cover R-type add (op 0x00, funct 0x20) with mem_ready=1.
- Required response: states IF,ID,EX,WB.
- In WB: reg_we=1, reg_dst_sel=01, wb_sel=00.
REQ-030 The bench SHALL cover lw (0x23) with mem_ready=0 for 3 MEM cycles.
- Required response: mem_re=1 for 4 MEM cycles.
- Then WB with wb_sel=01 and reg_dst_sel=00, for 8 cycles in total.
REQ-031 The bench SHALL cover beq (0x04) with zero=1 and with zero=0.
- zero=1: pc_we=1 and pc_sel=01 in EX.
- zero=0: pc_we=0, and the next state is IF in both cases.
REQ-032 The bench SHALL cover jal (0x03).
- Required response: WB asserts reg_we=1, reg_dst_sel=10, wb_sel=10, pc_we=1 and pc_sel=10 in the same cycle.
REQ-033 The bench SHALL cover op 0x3F.
- Required response: illegal=1 for exactly one cycle in ID, with no reg_we, mem_we or pc_we, then return to IF.
REQ-034 The bench SHALL cover reset=1 asserted mid-MEM of sw while mem_ready=0.
- Required response: the next state is IF with all strobes 0.
- After release, mem_re=1 and mem_we is never asserted.
